// File: rtl/uart_frame_pkg.sv
// Shared types and helpers for the UART framing stage.
// Imported by the frame receiver top level.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        HUNT0,
        HUNT1,
        LEN,
        PAYLOAD,
        CKSUM,
        DRAIN
    } state_e;

    localparam logic [7:0] SYNC0_DEF = 8'hA5;
    localparam logic [7:0] SYNC1_DEF = 8'h5A;

    // Pointers must hold the value MAX_WORDS itself, not just MAX_WORDS-1.
    function automatic int ptr_width(input int max_words);
        return $clog2(max_words + 1);
    endfunction

endpackage

// File: rtl/frame_word_buf.sv
// Frame payload storage: one write port, one asynchronous read port.
// No reset; contents are only read after being written by the current frame.
module frame_word_buf #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/uart_frame_rx.sv
// Sync-hunting frame receiver: buffers a length-prefixed payload and
// releases it to the word FIFO only after the XOR checksum matches.
module uart_frame_rx
    import uart_frame_pkg::*;
#(
    parameter int         MAX_WORDS      = 32,
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0] SYNC0          = SYNC0_DEF,
    parameter logic [7:0] SYNC1          = SYNC1_DEF,
    parameter int         ERR_CNT_WIDTH  = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [7:0]               i_rxq_data,
    input  logic                     i_rxq_empty,
    output logic                     o_rxq_deq,
    output logic [31:0]              o_word_data,
    output logic                     o_word_enq,
    input  logic                     i_word_full,
    output logic                     o_frame_ok,
    output logic                     o_frame_err,
    output logic [ERR_CNT_WIDTH-1:0] o_err_cnt,
    output logic                     o_busy
);

    localparam int PW = ptr_width(MAX_WORDS);
    localparam int AW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0]    MAXL  = 8'(MAX_WORDS);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

    state_e                   state_q, state_d;
    logic [PW-1:0]            len_q, len_d;
    logic [PW-1:0]            wptr_q, wptr_d;
    logic [PW-1:0]            rptr_q, rptr_d;
    logic [1:0]               lane_q, lane_d;
    logic [23:0]              asm_q, asm_d;
    logic [7:0]               chk_q, chk_d;
    logic [TW-1:0]            idle_q, idle_d;
    logic                     ok_q, ok_d;
    logic                     err_q, err_d;
    logic [ERR_CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic        take;
    logic        abort;
    logic        buf_we;
    logic [31:0] buf_rdata;

    assign take      = !i_rxq_empty && (state_q != DRAIN);
    assign o_rxq_deq = take;

    frame_word_buf #(
        .DEPTH (MAX_WORDS),
        .AW    (AW)
    ) u_buf (
        .i_clk   (i_clk),
        .i_we    (buf_we),
        .i_waddr (wptr_q[AW-1:0]),
        .i_wdata ({asm_q, i_rxq_data}),
        .i_raddr (rptr_q[AW-1:0]),
        .o_rdata (buf_rdata)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        lane_d     = lane_q;
        asm_d      = asm_q;
        chk_d      = chk_q;
        idle_d     = idle_q + TW'(1);
        ok_d       = 1'b0;
        err_d      = 1'b0;
        cnt_d      = cnt_q;
        abort      = 1'b0;
        buf_we     = 1'b0;
        o_word_enq = 1'b0;

        if (take || state_q inside {HUNT0, HUNT1, DRAIN}) begin
            idle_d = '0;
        end

        unique case (state_q)
            HUNT0: begin
                if (take && i_rxq_data == SYNC0) begin
                    state_d = HUNT1;
                end
            end
            HUNT1: begin
                if (take) begin
                    if (i_rxq_data == SYNC1) begin
                        state_d = LEN;
                    end else if (i_rxq_data != SYNC0) begin
                        state_d = HUNT0;
                    end
                end
            end
            LEN: begin
                if (take) begin
                    if (i_rxq_data == 8'd0 || i_rxq_data > MAXL) begin
                        abort = 1'b1;
                    end else begin
                        len_d   = PW'(i_rxq_data);
                        chk_d   = i_rxq_data;
                        wptr_d  = '0;
                        lane_d  = '0;
                        state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (take) begin
                    asm_d  = {asm_q[15:0], i_rxq_data};
                    chk_d  = chk_q ^ i_rxq_data;
                    lane_d = lane_q + 2'd1;
                    if (lane_q == 2'd3) begin
                        buf_we = 1'b1;
                        wptr_d = wptr_q + PW'(1);
                        if (wptr_q + PW'(1) == len_q) begin
                            state_d = CKSUM;
                        end
                    end
                end
            end
            CKSUM: begin
                if (take) begin
                    if (i_rxq_data == chk_q) begin
                        rptr_d  = '0;
                        state_d = DRAIN;
                    end else begin
                        abort = 1'b1;
                    end
                end
            end
            DRAIN: begin
                o_word_enq = !i_word_full;
                if (!i_word_full) begin
                    rptr_d = rptr_q + PW'(1);
                    if (rptr_q + PW'(1) == len_q) begin
                        state_d = HUNT0;
                        ok_d    = 1'b1;
                    end
                end
            end
            default: state_d = HUNT0;
        endcase

        // A byte arriving on the last idle cycle wins over the timeout.
        if (!take && idle_q == TLAST && state_q inside {LEN, PAYLOAD, CKSUM}) begin
            abort = 1'b1;
        end

        if (abort) begin
            state_d = HUNT0;
            err_d   = 1'b1;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + ERR_CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= HUNT0;
            len_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            lane_q  <= '0;
            asm_q   <= '0;
            chk_q   <= '0;
            idle_q  <= '0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            lane_q  <= lane_d;
            asm_q   <= asm_d;
            chk_q   <= chk_d;
            idle_q  <= idle_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_word_data = buf_rdata;
    assign o_frame_ok  = ok_q;
    assign o_frame_err = err_q;
    assign o_err_cnt   = cnt_q;
    assign o_busy      = (state_q != HUNT0);

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx: good/bad frames, resync, length
// errors, backpressure, timeout and reset during drain.
module tb_uart_frame_rx;

    typedef logic [7:0] bytes_t [$];

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rxq_data;
    logic        rxq_empty;
    logic        rxq_deq;
    logic [31:0] word_data;
    logic        word_enq;
    logic        word_full;
    logic        frame_ok;
    logic        frame_err;
    logic [15:0] err_cnt;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_deq_cyc = 0;

    logic [31:0] got[$];
    int          enq_cyc[$];
    int          n_ok = 0;
    int          n_err = 0;
    int          ok_cyc = 0;
    int          err_cyc = 0;

    uart_frame_rx #(
        .MAX_WORDS      (32),
        .TIMEOUT_CYCLES (16),
        .SYNC0          (8'hA5),
        .SYNC1          (8'h5A),
        .ERR_CNT_WIDTH  (16)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_rxq_data  (rxq_data),
        .i_rxq_empty (rxq_empty),
        .o_rxq_deq   (rxq_deq),
        .o_word_data (word_data),
        .o_word_enq  (word_enq),
        .i_word_full (word_full),
        .o_frame_ok  (frame_ok),
        .o_frame_err (frame_err),
        .o_err_cnt   (err_cnt),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (word_enq) begin
            got.push_back(word_data);
            enq_cyc.push_back(cyc);
        end
        if (frame_ok) begin
            n_ok++;
            ok_cyc = cyc;
        end
        if (frame_err) begin
            n_err++;
            err_cyc = cyc;
        end
    end

    task automatic expect_eq(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input int i);
        if (i < got.size()) return got[i];
        return 'x;
    endfunction

    function automatic int cyc_at(input int i);
        if (i < enq_cyc.size()) return enq_cyc[i];
        return -1000;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rxq_data  = b;
        rxq_empty = 1'b0;
        @(negedge clk);
        while (!rxq_deq && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!rxq_deq) expect_eq("deq_wait", {31'b0, rxq_deq}, 32'd1);
        last_deq_cyc = cyc;
        @(posedge clk);
        #1;
        rxq_empty = 1'b1;
    endtask

    task automatic send_seq(input bytes_t s);
        foreach (s[i]) send_byte(s[i]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    bytes_t      fr;
    logic [31:0] exp_w [32];
    int          g0, ok0, err0, bad_deq;
    logic [7:0]  ck;

    initial begin
        rst       = 1'b1;
        rxq_data  = 8'h00;
        rxq_empty = 1'b1;
        word_full = 1'b0;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        expect_eq("rst_deq", {31'b0, rxq_deq}, 0);
        expect_eq("rst_enq", {31'b0, word_enq}, 0);
        expect_eq("rst_ok", {31'b0, frame_ok}, 0);
        expect_eq("rst_err", {31'b0, frame_err}, 0);
        expect_eq("rst_cnt", {16'b0, err_cnt}, 0);
        expect_eq("rst_busy", {31'b0, busy}, 0);
        idle(1);

        // Good frame: checksum 02^11^22^33^44^55^66^77^88 = 8A
        g0 = got.size(); ok0 = n_ok;
        fr = '{8'hA5, 8'h5A, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
               8'h55, 8'h66, 8'h77, 8'h88, 8'h8A};
        send_seq(fr);
        idle(6);
        expect_eq("good_n", got.size() - g0, 2);
        expect_eq("good_w0", word_at(g0), 32'h11223344);
        expect_eq("good_w1", word_at(g0 + 1), 32'h55667788);
        expect_eq("good_lat", cyc_at(g0) - last_deq_cyc, 1);
        expect_eq("good_b2b", cyc_at(g0 + 1) - cyc_at(g0), 1);
        expect_eq("good_okn", n_ok - ok0, 1);
        expect_eq("good_okc", ok_cyc - cyc_at(g0 + 1), 1);
        expect_eq("good_cnt", {16'b0, err_cnt}, 0);

        // Bad checksum, then the same frame with a good one
        g0 = got.size(); err0 = n_err; ok0 = n_ok;
        fr[11] = 8'h8B;
        send_seq(fr);
        idle(6);
        expect_eq("badck_n", got.size() - g0, 0);
        expect_eq("badck_err", n_err - err0, 1);
        expect_eq("badck_cnt", {16'b0, err_cnt}, 1);
        fr[11] = 8'h8A;
        send_seq(fr);
        idle(6);
        expect_eq("after_n", got.size() - g0, 2);
        expect_eq("after_w0", word_at(g0), 32'h11223344);
        expect_eq("after_w1", word_at(g0 + 1), 32'h55667788);
        expect_eq("after_ok", n_ok - ok0, 1);

        // Garbage and repeated SYNC0 before the header
        g0 = got.size();
        fr = '{8'h00, 8'hA5, 8'hA5, 8'h5A, 8'h01, 8'hDE, 8'hAD,
               8'hBE, 8'hEF, 8'h23};
        send_seq(fr);
        idle(4);
        expect_eq("resync_n", got.size() - g0, 1);
        expect_eq("resync_w", word_at(g0), 32'hDEADBEEF);

        // Length 0 and length 33
        do_reset();
        g0 = got.size(); err0 = n_err;
        fr = '{8'hA5, 8'h5A, 8'h00, 8'hA5, 8'h5A, 8'h21};
        send_seq(fr);
        idle(4);
        expect_eq("len_err", n_err - err0, 2);
        expect_eq("len_cnt", {16'b0, err_cnt}, 2);
        expect_eq("len_n", got.size() - g0, 0);

        // 32-word frame with A5 bytes in the payload, drained under backpressure
        g0 = got.size(); ok0 = n_ok;
        fr = '{8'hA5, 8'h5A, 8'h20};
        ck = 8'h20;
        for (int i = 0; i < 32; i++) begin
            exp_w[i] = {8'(i), 8'hA5, 8'h5A ^ 8'(i), ~8'(i)};
            for (int k = 3; k >= 0; k--) begin
                fr.push_back(exp_w[i][k*8 +: 8]);
                ck = ck ^ exp_w[i][k*8 +: 8];
            end
        end
        fr.push_back(ck);
        send_seq(fr);
        rxq_data  = 8'h00;
        rxq_empty = 1'b0;
        bad_deq   = 0;
        for (int i = 0; i < 400; i++) begin
            word_full = (i % 4 != 3);
            @(negedge clk);
            if (rxq_deq && busy) bad_deq++;
            if (n_ok > ok0) break;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        word_full = 1'b0;
        rxq_empty = 1'b1;
        idle(2);
        expect_eq("bp_n", got.size() - g0, 32);
        for (int i = 0; i < 32; i++) begin
            expect_eq($sformatf("bp_w%0d", i), word_at(g0 + i), exp_w[i]);
        end
        expect_eq("bp_deq", bad_deq, 0);
        expect_eq("bp_ok", n_ok - ok0, 1);

        // Timeout after 5 payload bytes
        g0 = got.size(); err0 = n_err;
        fr = '{8'hA5, 8'h5A, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        send_seq(fr);
        for (int i = 0; i < 40; i++) begin
            if (n_err > err0) break;
            idle(1);
        end
        expect_eq("to_err", n_err - err0, 1);
        expect_eq("to_cyc", err_cyc - last_deq_cyc, 17);
        expect_eq("to_cnt", {16'b0, err_cnt}, 3);
        expect_eq("to_busy", {31'b0, busy}, 0);
        expect_eq("to_n", got.size() - g0, 0);
        // 01^CA^FE^BA^BE = 31
        fr = '{8'hA5, 8'h5A, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h31};
        send_seq(fr);
        idle(4);
        expect_eq("to_next_n", got.size() - g0, 1);
        expect_eq("to_next_w", word_at(g0), 32'hCAFEBABE);

        // Reset while stalled in DRAIN; 01^12^34^56^78 = 09
        g0 = got.size(); ok0 = n_ok; err0 = n_err;
        word_full = 1'b1;
        fr = '{8'hA5, 8'h5A, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
        send_seq(fr);
        idle(3);
        @(negedge clk);
        expect_eq("drain_busy", {31'b0, busy}, 1);
        idle(1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        word_full = 1'b0;
        @(negedge clk);
        expect_eq("mrst_busy", {31'b0, busy}, 0);
        expect_eq("mrst_enq", {31'b0, word_enq}, 0);
        expect_eq("mrst_deq", {31'b0, rxq_deq}, 0);
        expect_eq("mrst_cnt", {16'b0, err_cnt}, 0);
        idle(10);
        expect_eq("mrst_n", got.size() - g0, 0);
        expect_eq("mrst_ok", n_ok - ok0, 0);
        expect_eq("mrst_err", n_err - err0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
